// File: rtl/seg_pipe_adder_if.sv
// Operand/result handshake bundle for seg_pipe_adder.
// The producer/consumer side uses master; the adder uses slave.
interface seg_pipe_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             co;
    logic             ovf;

    modport master (
        output in_valid, a, b, ci, sub, out_ready,
        input  in_ready, out_valid, sum, co, ovf
    );

    modport slave (
        input  in_valid, a, b, ci, sub, out_ready,
        output in_ready, out_valid, sum, co, ovf
    );
endinterface

// File: rtl/seg_pipe_adder.sv
// Elastic add/subtract pipeline: the carry chain is cut into STAGES segments
// of SEG bits, and each register stage resolves one segment.
module seg_pipe_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 4
) (
    input  logic           clk,
    input  logic           rst,
    seg_pipe_adder_if.slave bus
);
    localparam int SEG = WIDTH / STAGES;
    // Stage k carries WIDTH-k*SEG not-yet-added operand bits and k*SEG result bits;
    // all stages are packed back to back into flat vectors.
    localparam int OPW   = (STAGES - 1) * WIDTH - (SEG * (STAGES - 1) * STAGES) / 2;
    localparam int OPW_D = (OPW > 0) ? OPW : 1;
    localparam int SMW   = (SEG * STAGES * (STAGES + 1)) / 2;

    logic [STAGES:1] v_q, v_d;
    logic [STAGES:1] c_q, c_d;
    logic [STAGES:1] rdy;
    logic [SMW-1:0]  sum_q, sum_d;
    logic [OPW_D-1:0] a_q, a_d;
    logic [OPW_D-1:0] b_q, b_d;
    logic            ovf_q, ovf_d;

    logic [WIDTH-1:0] bp;
    logic             c0;

    assign bp = bus.sub ? ~bus.b : bus.b;
    assign c0 = bus.sub ? ~bus.ci : bus.ci;

    // Ready ripples back from the consumer so a full pipe still advances.
    always_comb begin
        logic chain;
        // NOTE: blocking assignments in combinational logic, and every output gets a default first so no latch is inferred.
        rdy   = '0;
        chain = bus.out_ready;
        for (int k = STAGES; k >= 1; k--) begin
            chain  = ~v_q[k] | chain;
            rdy[k] = chain;
        end
    end

    if (OPW == 0) begin : g_no_ops
        assign a_d = '0;
        assign b_d = '0;
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int K    = g + 1;
        localparam int LO   = g * SEG;
        localparam int UW   = WIDTH - K * SEG;
        localparam int SOFF = (SEG * g * K) / 2;
        localparam int OOFF = g * WIDTH - (SEG * g * K) / 2;

        logic [SEG-1:0]    seg_a, seg_b, seg_s;
        logic              cin, cout, vin, load;
        logic [LO+SEG-1:0] new_sum;

        if (g == 0) begin : g_first
            assign seg_a   = bus.a[SEG-1:0];
            assign seg_b   = bp[SEG-1:0];
            assign cin     = c0;
            assign vin     = bus.in_valid;
            assign new_sum = seg_s;
            if (UW > 0) begin : g_up
                assign a_d[OOFF +: UW] = load ? bus.a[WIDTH-1:SEG] : a_q[OOFF +: UW];
                assign b_d[OOFF +: UW] = load ? bp[WIDTH-1:SEG]    : b_q[OOFF +: UW];
            end
        end else begin : g_next
            localparam int POOFF = (g - 1) * WIDTH - (SEG * (g - 1) * g) / 2;
            localparam int PSOFF = (SEG * (g - 1) * g) / 2;
            assign seg_a   = a_q[POOFF +: SEG];
            assign seg_b   = b_q[POOFF +: SEG];
            assign cin     = c_q[g];
            assign vin     = v_q[g];
            assign new_sum = {seg_s, sum_q[PSOFF +: LO]};
            if (UW > 0) begin : g_up
                assign a_d[OOFF +: UW] = load ? a_q[POOFF+SEG +: UW] : a_q[OOFF +: UW];
                assign b_d[OOFF +: UW] = load ? b_q[POOFF+SEG +: UW] : b_q[OOFF +: UW];
            end
        end

        assign {cout, seg_s} = {1'b0, seg_a} + {1'b0, seg_b} + {{SEG{1'b0}}, cin};

        // Data only moves with a valid beat, so the outputs hold their last result.
        assign load                   = rdy[K] & vin;
        assign v_d[K]                 = rdy[K] ? vin : v_q[K];
        assign c_d[K]                 = load ? cout : c_q[K];
        assign sum_d[SOFF +: LO+SEG]  = load ? new_sum : sum_q[SOFF +: LO+SEG];

        if (K == STAGES) begin : g_last
            assign ovf_d = load ? ((seg_a[SEG-1] == seg_b[SEG-1]) && (seg_s[SEG-1] != seg_a[SEG-1]))
                                : ovf_q;
        end
    end

    // NOTE: the datapath registers are reset too, because sum/co/ovf must read 0 out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q   <= '0;
            c_q   <= '0;
            sum_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            v_q   <= v_d;
            c_q   <= c_d;
            sum_q <= sum_d;
            a_q   <= a_d;
            b_q   <= b_d;
            ovf_q <= ovf_d;
        end
    end

    assign bus.in_ready  = rdy[1];
    assign bus.out_valid = v_q[STAGES];
    assign bus.sum       = sum_q[SMW-1 -: WIDTH];
    assign bus.co        = c_q[STAGES];
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seg_pipe_adder.sv
// Self-checking bench for seg_pipe_adder: directed 8-bit cases, stall/drain,
// a randomized 32-bit elastic stream against an arithmetic model, and mid-flight reset.
module tb_seg_pipe_adder;
    localparam int LIMIT = 20000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg_pipe_adder_if #(.WIDTH(8))  if8 ();
    seg_pipe_adder_if #(.WIDTH(32)) if32 ();

    seg_pipe_adder #(.WIDTH(8),  .STAGES(4)) dut8  (.clk(clk), .rst(rst), .bus(if8));
    seg_pipe_adder #(.WIDTH(32), .STAGES(4)) dut32 (.clk(clk), .rst(rst), .bus(if32));

    int tests = 0;
    int fails = 0;
    logic [33:0] exp_q[$];

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Plain integer arithmetic: {co, ovf, sum} for a WIDTH=w add or subtract.
    function automatic logic [33:0] ref_result(int w, longint a, longint b, bit ci, bit sub);
        longint m    = longint'(1) << w;
        longint half = m / 2;
        longint sa   = (a >= half) ? a - m : a;
        longint sb   = (b >= half) ? b - m : b;
        longint us, ss;
        bit co, ovf;
        logic [31:0] s;
        if (sub) begin
            us = a - b - longint'(ci);
            ss = sa - sb - longint'(ci);
            co = (a >= b + longint'(ci));
        end else begin
            us = a + b + longint'(ci);
            ss = sa + sb + longint'(ci);
            co = (us >= m);
        end
        us  = ((us % m) + m) % m;
        ovf = (ss < -half) || (ss > half - 1);
        s   = 32'(us);
        return {co, ovf, s};
    endfunction

    // One beat through the empty 8-bit pipe with out_ready high.
    task automatic run8(string tag, logic [7:0] a, logic [7:0] b, logic ci, logic sub,
                        logic [7:0] e_sum, logic e_co, logic e_ovf);
        int cyc;
        logic acc;
        @(posedge clk); #1;
        if8.in_valid = 1'b1; if8.a = a; if8.b = b; if8.ci = ci; if8.sub = sub;
        @(negedge clk);
        acc = if8.in_ready;
        check({tag, "_in_ready"}, acc, 1);
        @(posedge clk); #1;
        if8.in_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!if8.out_valid && cyc <= 10);
        check({tag, "_latency"}, cyc, 4);
        check({tag, "_result"}, {if8.co, if8.ovf, if8.sum}, {e_co, e_ovf, e_sum});
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        logic acc;
        logic stale;

        rst = 1'b1;
        if8.in_valid = 1'b0; if8.a = '0; if8.b = '0; if8.ci = 1'b0; if8.sub = 1'b0; if8.out_ready = 1'b1;
        if32.in_valid = 1'b0; if32.a = '0; if32.b = '0; if32.ci = 1'b0; if32.sub = 1'b0; if32.out_ready = 1'b1;

        #12;
        check("reset_out_valid", if8.out_valid, 0);
        check("reset_sum", if8.sum, 0);
        check("reset_co_ovf", {if8.co, if8.ovf}, 0);
        check("reset_out_valid32", if32.out_valid, 0);
        #11 rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready", if8.in_ready, 1);

        // Directed arithmetic boundaries.
        run8("add_ff_01",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("add_7f_01",   8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("add_80_80_c", 8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, 1'b1);
        run8("sub_05_07",   8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
        run8("sub_10_01_b", 8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0);

        // Stall: six beats offered against a blocked consumer.
        @(posedge clk); #1;
        if8.out_ready = 1'b0;
        idx = 0;
        if8.in_valid = 1'b1; if8.a = 8'(idx); if8.b = 8'h10; if8.ci = 1'b0; if8.sub = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            acc = if8.in_valid & if8.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if8.a = 8'(idx);
        end
        check("stall_accepted", idx, 4);
        @(negedge clk);
        check("stall_in_ready", if8.in_ready, 0);
        @(posedge clk); #1;
        if8.out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            check("drain_valid", if8.out_valid, 1);
            check("drain_sum", if8.sum, 8'h10 + 8'(j));
            check("drain_in_ready", if8.in_ready, 1);
            acc = if8.in_valid & if8.in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (idx < 6) if8.a = 8'(idx);
            else         if8.in_valid = 1'b0;
        end
        @(negedge clk);
        check("drain_empty", if8.out_valid, 0);

        // Randomized elastic stream on the 32-bit instance.
        fork
            begin : producer
                int sent = 0;
                int cyc  = 0;
                while (sent < 1000 && cyc < LIMIT) begin
                    @(posedge clk); #1;
                    if32.in_valid = ($urandom_range(0, 3) != 0);
                    if32.a   = $urandom;
                    if32.b   = $urandom;
                    if32.ci  = 1'($urandom_range(0, 1));
                    if32.sub = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (if32.in_valid && if32.in_ready) begin
                        exp_q.push_back(ref_result(32, longint'(if32.a), longint'(if32.b), if32.ci, if32.sub));
                        sent++;
                    end
                    cyc++;
                end
                @(posedge clk); #1;
                if32.in_valid = 1'b0;
            end
            begin : consumer
                int got = 0;
                int cyc = 0;
                logic [33:0] e;
                while (got < 1000 && cyc < LIMIT) begin
                    @(posedge clk); #1;
                    if32.out_ready = ($urandom_range(0, 2) != 0);
                    @(negedge clk);
                    if (if32.out_valid && if32.out_ready) begin
                        if (exp_q.size() == 0) begin
                            check("rand_unexpected_beat", 1, 0);
                        end else begin
                            e = exp_q.pop_front();
                            check("rand_beat", {if32.co, if32.ovf, if32.sum}, e);
                        end
                        got++;
                    end
                    cyc++;
                end
                check("rand_beats_received", got, 1000);
            end
        join
        check("rand_queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        if32.out_ready = 1'b1;

        // Reset with three beats in flight.
        if8.out_ready = 1'b0;
        if8.in_valid = 1'b1; if8.b = 8'h01; if8.ci = 1'b0; if8.sub = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if8.a = 8'h30 + 8'(i);
            @(posedge clk); #1;
        end
        if8.in_valid = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_valid", if8.out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async_reset_valid", if8.out_valid, 0);
        check("async_reset_sum", if8.sum, 0);
        #4 rst = 1'b0;
        if8.out_ready = 1'b1;
        stale = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (if8.out_valid) stale = 1'b1;
        end
        check("post_reset_no_stale", stale, 0);
        run8("post_reset_beat", 8'h22, 8'h11, 1'b1, 1'b0, 8'h34, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
